// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register (main + skid) with a fully registered in_ready.
// Optional macro PIPE_SKID_LEVEL_EN adds a registered 2-bit occupancy output `level`.
module pipe_skid_reg #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPE_SKID_LEVEL_EN
  ,
  output logic [1:0]       level
`endif
);

  // State encoding mirrors {main valid, skid valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             ready_q, ready_d;
  logic             main_v;
  logic             in_fire, out_fire;

  assign main_v    = state_q[1];
  assign in_ready  = ready_q & ce;
  assign out_valid = main_v & ce;
  assign out_data  = main_data_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d     = ONE;
          main_data_d = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_data_d = in_data;
        end else if (in_fire) begin
          state_d     = FULL;
          skid_data_d = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain into main can happen.
        if (out_fire) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    ready_d = (state_d != FULL);
  end

`ifdef PIPE_SKID_LEVEL_EN
  logic [1:0] level_q, level_d;

  always_comb begin
    level_d = 2'd0;
    case (state_d)
      ONE:     level_d = 2'd1;
      FULL:    level_d = 2'd2;
      default: level_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 2'd0;
    end else if (ce) begin
      level_q <= level_d;
    end
  end

  assign level = level_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      ready_q     <= 1'b0;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else if (ce) begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a driver with an occupancy model pushes accepted
// beats into a queue; a separate monitor pops and compares on every output handshake.
module tb_pipe_skid_reg;
  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst, ce, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
`ifdef PIPE_SKID_LEVEL_EN
  logic [1:0]   level;
`endif

  pipe_skid_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PIPE_SKID_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];
  int           occ      = 0;
  logic         ready_m  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after a rising edge, check handshake outputs
  // against the model, then advance the model as the next edge will.
  task automatic step(input logic iv, input logic [W-1:0] d, input logic orr,
                      input logic cee, input logic rr);
    logic inf, outf;
    in_valid  = iv;
    in_data   = d;
    out_ready = orr;
    ce        = cee;
    rst       = rr;
    #1;
    check("in_ready", 32'(in_ready), 32'(ready_m & cee));
    check("out_valid", 32'(out_valid), 32'((occ > 0) & cee));
`ifdef PIPE_SKID_LEVEL_EN
    check("level", 32'(level), 32'(occ));
`endif
    if (rr) begin
      occ     = 0;
      ready_m = 1'b0;
      exp_q.delete();
    end else if (cee) begin
      inf  = iv & ready_m;
      outf = (occ > 0) & orr;
      if (inf) exp_q.push_back(d);
      occ     = occ + (inf ? 1 : 0) - (outf ? 1 : 0);
      ready_m = (occ != 2);
    end
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got %0h expected no beat", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL out_data: got %0h expected %0h", out_data, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ce = 1'b1; in_valid = 1'b1; in_data = 18'h3; out_ready = 1'b0;
    @(posedge clk);
    #2;

    // Reset held with in_valid asserted
    repeat (3) step(1'b1, 18'h5, 1'b0, 1'b1, 1'b1);
    check("rst_out_data", 32'(out_data), 32'h0);
    step(1'b1, 18'h7, 1'b1, 1'b1, 1'b0);
    check("ready_after_release", 32'(in_ready), 32'h1);

    // Streaming 1..4
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b0, 18'h0, 1'b1, 1'b1, 1'b0);

    // Stall fills the skid entry
    step(1'b1, 18'h0A, 1'b0, 1'b1, 1'b0);
    check("stall_hold0", 32'(out_data), 32'h0A);
    step(1'b1, 18'h0B, 1'b0, 1'b1, 1'b0);
    repeat (2) begin
      step(1'b0, 18'h0, 1'b0, 1'b1, 1'b0);
      check("stall_hold", 32'(out_data), 32'h0A);
    end
    repeat (3) step(1'b0, 18'h0, 1'b1, 1'b1, 1'b0);

    // Enable freeze while FULL
    step(1'b1, 18'h21, 1'b0, 1'b1, 1'b0);
    step(1'b1, 18'h22, 1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b1, 18'h99, 1'b1, 1'b0, 1'b0);
    check("freeze_data", 32'(out_data), 32'h21);
    repeat (3) step(1'b0, 18'h0, 1'b1, 1'b1, 1'b0);

    // Reset while FULL discards both entries
    step(1'b1, 18'h11, 1'b0, 1'b1, 1'b0);
    step(1'b1, 18'h22, 1'b0, 1'b1, 1'b0);
    step(1'b0, 18'h0, 1'b0, 1'b1, 1'b1);
    check("rst_full_data", 32'(out_data), 32'h0);
    step(1'b0, 18'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 18'h33, 1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b0, 18'h0, 1'b1, 1'b1, 1'b0);

    // Random handshakes and clock enable
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), 1'b0);

    // Drain and confirm nothing was lost
    repeat (4) step(1'b0, 18'h0, 1'b1, 1'b1, 1'b0);
    check("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
